// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a W-bit pattern out MSB first, optionally
// repeated with idle gaps, with frame_end aligned to each frame's last bit.
module seq_pattern_tx #(
  parameter int           W           = 4,
  parameter logic [W-1:0] DEFAULT_PAT = 4'b1011,
  parameter int           RW          = 4,
  parameter int           GW          = 4,
  parameter logic         IDLE_LEVEL  = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [W-1:0]  pattern_in,
  input  logic [RW-1:0] repeat_in,
  input  logic [GW-1:0] gap_in,
  input  logic          abort,
  output logic          a_out,
  output logic          bit_valid,
  output logic          busy,
  output logic          frame_end,
  output logic          done
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;
  localparam logic [IW-1:0] IDX_MAX = IW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [W-1:0]  pat_r, pat_s;
  logic [RW-1:0] frames_r, frames_s;
  logic [GW-1:0] gap_q_r, gap_q_s;
  logic [GW-1:0] gap_cnt_r, gap_cnt_s;
  logic [IW-1:0] idx_r, idx_s;

  logic a_out_s, bit_valid_s, busy_s, frame_end_s, done_s;

  // Next-state and counter update; abort overrides everything including start.
  always_comb begin
    state_s   = state_r;
    pat_s     = pat_r;
    frames_s  = frames_r;
    gap_q_s   = gap_q_r;
    gap_cnt_s = gap_cnt_r;
    idx_s     = idx_r;
    if (abort) begin
      state_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            pat_s    = (pattern_in == {W{1'b0}}) ? DEFAULT_PAT : pattern_in;
            frames_s = (repeat_in == {RW{1'b0}}) ? RW'(1) : repeat_in;
            gap_q_s  = gap_in;
            idx_s    = IDX_MAX;
            state_s  = S_SEND;
          end else begin
            state_s = S_IDLE;
          end
        end
        S_SEND: begin
          if (idx_r == {IW{1'b0}}) begin
            frames_s = frames_r - RW'(1);
            if (frames_r <= RW'(1)) begin
              state_s = S_DONE;
            end else if (gap_q_r != {GW{1'b0}}) begin
              state_s   = S_GAP;
              gap_cnt_s = gap_q_r;
            end else begin
              idx_s = IDX_MAX;
            end
          end else begin
            idx_s = idx_r - IW'(1);
          end
        end
        S_GAP: begin
          if (gap_cnt_r <= GW'(1)) begin
            state_s = S_SEND;
            idx_s   = IDX_MAX;
          end else begin
            gap_cnt_s = gap_cnt_r - GW'(1);
          end
        end
        S_DONE: begin
          state_s = S_IDLE;
        end
        default: begin
          state_s = S_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so the registered copy shows
  // the bit being sent in the same cycle the state register holds it.
  always_comb begin
    a_out_s     = IDLE_LEVEL;
    bit_valid_s = 1'b0;
    frame_end_s = 1'b0;
    busy_s      = (state_s != S_IDLE);
    done_s      = (state_s == S_DONE);
    if (state_s == S_SEND) begin
      a_out_s     = pat_s[idx_s];
      bit_valid_s = 1'b1;
      frame_end_s = (idx_s == {IW{1'b0}});
    end else begin
      a_out_s     = IDLE_LEVEL;
      bit_valid_s = 1'b0;
    end
  end

  // State, counters and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= S_IDLE;
      pat_r     <= {W{1'b0}};
      frames_r  <= {RW{1'b0}};
      gap_q_r   <= {GW{1'b0}};
      gap_cnt_r <= {GW{1'b0}};
      idx_r     <= {IW{1'b0}};
      a_out     <= IDLE_LEVEL;
      bit_valid <= 1'b0;
      busy      <= 1'b0;
      frame_end <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_r   <= state_s;
      pat_r     <= pat_s;
      frames_r  <= frames_s;
      gap_q_r   <= gap_q_s;
      gap_cnt_r <= gap_cnt_s;
      idx_r     <= idx_s;
      a_out     <= a_out_s;
      bit_valid <= bit_valid_s;
      busy      <= busy_s;
      frame_end <= frame_end_s;
      done      <= done_s;
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: directed plan items plus random
// transfers compared against a cycle-list reference model.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] pattern_in = 4'd0;
  logic [3:0] repeat_in = 4'd0;
  logic [3:0] gap_in = 4'd0;
  logic       abort = 1'b0;
  logic       a_out, bit_valid, busy, frame_end, done;

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] IDLE_OUT = 5'b00000;

  seq_pattern_tx dut (
    .clk(clk), .reset(reset), .start(start), .pattern_in(pattern_in),
    .repeat_in(repeat_in), .gap_in(gap_in), .abort(abort),
    .a_out(a_out), .bit_valid(bit_valid), .busy(busy),
    .frame_end(frame_end), .done(done)
  );

  always #5 clk = ~clk;

  // Observed outputs as {a_out, bit_valid, busy, frame_end, done}
  function automatic logic [4:0] obs();
    return {a_out, bit_valid, busy, frame_end, done};
  endfunction

  task automatic check(input string tag, input int cyc, input logic [4:0] exp);
    logic [4:0] o;
    o = obs();
    checks++;
    assert (o === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: got {a,v,busy,fe,done}=%b expected %b", tag, cyc, o, exp);
    end
  endtask

  // Expected per-cycle outputs from cycle 1 after start up to the first idle cycle.
  task automatic build_model(input logic [3:0] pat, input logic [3:0] rep,
                             input logic [3:0] gap, output logic [4:0] q[$]);
    logic [3:0] epat;
    int frames;
    q = {};
    epat = (pat == 4'd0) ? 4'b1011 : pat;
    frames = (rep == 4'd0) ? 1 : int'(rep);
    for (int f = 0; f < frames; f++) begin
      for (int b = 3; b >= 0; b--)
        q.push_back({epat[b], 1'b1, 1'b1, (b == 0), 1'b0});
      if (f < frames - 1)
        for (int g = 0; g < int'(gap); g++) q.push_back(5'b00100);
    end
    q.push_back(5'b00101);
    q.push_back(IDLE_OUT);
  endtask

  // Called #1 after a clock edge with the DUT idle. abort_at>0 aborts after
  // that cycle; noise toggles start and the capture inputs while busy.
  task automatic run_xfer(input string tag, input logic [3:0] pat, input logic [3:0] rep,
                          input logic [3:0] gap, input int abort_at, input bit noise);
    logic [4:0] q[$];
    build_model(pat, rep, gap, q);
    pattern_in = pat; repeat_in = rep; gap_in = gap; start = 1'b1; abort = 1'b0;
    for (int k = 0; k < q.size(); k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      check(tag, k + 1, q[k]);
      if (abort_at > 0 && k + 1 == abort_at) begin
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check({tag, "_abort"}, k + 2, IDLE_OUT);
        return;
      end
      if (noise && k < q.size() - 1) begin
        start = 1'($urandom_range(0, 1));
        pattern_in = 4'($urandom); repeat_in = 4'($urandom); gap_in = 4'($urandom);
      end
    end
    start = 1'b0;
  endtask

  initial begin
    #2;
    check("reset_state", 0, IDLE_OUT);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("idle_after_reset", 0, IDLE_OUT);

    run_xfer("single_1011", 4'b1011, 4'd1, 4'd0, 0, 1'b0);
    run_xfer("default_pat", 4'b0000, 4'd0, 4'd0, 0, 1'b0);
    run_xfer("rep3_gap2_noise", 4'b1101, 4'd3, 4'd2, 0, 1'b1);
    run_xfer("back_to_back", 4'b1011, 4'd2, 4'd0, 0, 1'b0);

    // Abort on cycle 2, restart on cycle 3 with first bit on cycle 4
    pattern_in = 4'b1011; repeat_in = 4'd3; gap_in = 4'd1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("abort_c1", 1, 5'b11100);
    @(posedge clk); #1;
    check("abort_c2", 2, 5'b01100);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_c3", 3, IDLE_OUT);
    run_xfer("restart_after_abort", 4'b0110, 4'd1, 4'd0, 0, 1'b0);

    // abort and start together in IDLE
    abort = 1'b1; start = 1'b1; pattern_in = 4'b1111;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    check("abort_beats_start", 1, IDLE_OUT);
    @(posedge clk); #1;
    check("abort_beats_start_hold", 2, IDLE_OUT);

    // Asynchronous reset mid-bit
    pattern_in = 4'b1011; repeat_in = 4'd2; gap_in = 4'd1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("pre_reset_bit", 1, 5'b11100);
    #2 reset = 1'b1;
    #1 check("async_reset", 1, IDLE_OUT);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check("post_reset_idle", 2, IDLE_OUT);
    run_xfer("after_reset", 4'b1001, 4'd2, 4'd1, 0, 1'b1);

    // Random transfers, some aborted part-way
    for (int t = 0; t < 25; t++) begin
      logic [3:0] p, r, g;
      int frames, total, ab;
      p = 4'($urandom); r = 4'($urandom_range(0, 3)); g = 4'($urandom_range(0, 3));
      frames = (r == 4'd0) ? 1 : int'(r);
      total = frames * 4 + (frames - 1) * int'(g) + 1;
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, total)) : 0;
      run_xfer("random", p, r, g, ab, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
